// File: rtl/spi_pkg.sv
// Shared constants for the SPI transfer sequencer.
// Holds the sequencer state encoding and the default word width / FIFO depth.
package spi_pkg;

  localparam int SPI_DWIDTH = 8;
  localparam int SPI_DEPTH  = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous show-ahead FIFO used for both the TX and RX word buffers.
// A push is accepted when not full, or when full with a same-cycle pop.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DWIDTH = SPI_DWIDTH,
  parameter int DEPTH  = SPI_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_en;
  logic              rd_en;

  assign full  = (32'(count) == DEPTH);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// Sequencer feeding len words from a TX FIFO through an spi_core host port.
// Define SPI_XFER_SEQ_IRQ_EN to add a one-cycle completion irq output.
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int DWIDTH   = SPI_DWIDTH,
  parameter int DEPTH    = SPI_DEPTH,
  parameter int SS_SETUP = 2
) (
`ifdef SPI_XFER_SEQ_IRQ_EN
  output logic              irq,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_push,
  output logic              tx_full,
  output logic [DWIDTH-1:0] rx_data,
  input  logic              rx_pop,
  output logic              rx_empty,
  output logic              busy,
  output logic              rx_ovf,
  output logic              ss_n,
  output logic              core_cs,
  output logic              core_wr,
  output logic              core_rd,
  output logic [DWIDTH-1:0] core_din,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_done
);

  localparam int         SETUP_LAST = (SS_SETUP > 0) ? SS_SETUP - 1 : 0;
  localparam logic [7:0] TMR_LAST   = 8'(SETUP_LAST);

  logic [2:0]        state;
  logic [7:0]        cnt;
  logic [7:0]        tmr;
  logic [DWIDTH-1:0] tx_head;
  logic              tx_empty;
  logic              rx_full;
  logic              issue;
  logic              cap;
  logic              drop;

  assign core_rd = 1'b0;
  assign issue   = (state == S_ISSUE) && !tx_empty && core_done;
  assign cap     = (state == S_WAIT_DONE) && core_done;
  assign drop    = cap && rx_full && !rx_pop;

  spi_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (issue),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (core_dout),
    .pop   (rx_pop),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Transaction FSM; core strobes are single-cycle and default low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tmr      <= '0;
      busy     <= 1'b0;
      ss_n     <= 1'b1;
      rx_ovf   <= 1'b0;
      core_cs  <= 1'b0;
      core_wr  <= 1'b0;
      core_din <= '0;
`ifdef SPI_XFER_SEQ_IRQ_EN
      irq      <= 1'b0;
`endif
    end else begin
      core_cs <= 1'b0;
      core_wr <= 1'b0;
`ifdef SPI_XFER_SEQ_IRQ_EN
      irq     <= 1'b0;
`endif
      if (drop) rx_ovf <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start && len != 8'd0) begin
            cnt    <= len;
            tmr    <= '0;
            rx_ovf <= 1'b0;
            ss_n   <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == TMR_LAST) state <= S_ISSUE;
          else tmr <= tmr + 8'd1;
        end
        S_ISSUE: begin
          if (issue) begin
            core_cs  <= 1'b1;
            core_wr  <= 1'b1;
            core_din <= tx_head;
            state    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!core_done) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (core_done) begin
            cnt   <= cnt - 8'd1;
            tmr   <= '0;
            state <= (cnt == 8'd1) ? S_HOLD : S_ISSUE;
          end
        end
        S_HOLD: begin
          if (tmr == TMR_LAST) begin
            ss_n  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
`ifdef SPI_XFER_SEQ_IRQ_EN
            irq   <= 1'b1;
`endif
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a behavioural spi_core stand-in.
// The stand-in answers each word w with w ^ 8'h99.
module tb_spi_xfer_seq;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_push = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_pop = 1'b0;
  logic       rx_empty;
  logic       busy;
  logic       rx_ovf;
  logic       ss_n;
  logic       core_cs;
  logic       core_wr;
  logic       core_rd;
  logic [7:0] core_din;
  logic [7:0] core_dout = 8'd0;
  logic       core_done = 1'b1;
`ifdef SPI_XFER_SEQ_IRQ_EN
  logic       irq;
  int         irq_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] wr_log [64];
  int         wr_cnt = 0;
  int         dev_cnt = 0;
  logic [7:0] dev_res = 8'd0;

  spi_xfer_seq #(
    .DWIDTH   (8),
    .DEPTH    (4),
    .SS_SETUP (SS)
  ) dut (
`ifdef SPI_XFER_SEQ_IRQ_EN
    .irq       (irq),
`endif
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .tx_data   (tx_data),
    .tx_push   (tx_push),
    .tx_full   (tx_full),
    .rx_data   (rx_data),
    .rx_pop    (rx_pop),
    .rx_empty  (rx_empty),
    .busy      (busy),
    .rx_ovf    (rx_ovf),
    .ss_n      (ss_n),
    .core_cs   (core_cs),
    .core_wr   (core_wr),
    .core_rd   (core_rd),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_done (core_done)
  );

  always #5 clk = ~clk;

  // spi_core stand-in: 10-cycle busy window per accepted write
  always @(posedge clk) begin
    if (core_cs && core_wr) begin
      wr_log[wr_cnt % 64] <= core_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (dev_cnt == 0 && core_cs && core_wr && core_done) begin
      core_done <= 1'b0;
      dev_cnt   <= 10;
      dev_res   <= core_din ^ 8'h99;
    end else if (dev_cnt == 1) begin
      core_done <= 1'b1;
      core_dout <= dev_res;
      dev_cnt   <= 0;
    end else if (dev_cnt > 1) begin
      dev_cnt <= dev_cnt - 1;
    end
  end

`ifdef SPI_XFER_SEQ_IRQ_EN
  always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;
`endif

  task automatic push_word(input logic [7:0] d);
    tx_data = d;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic pop_word();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles", name, busy, maxc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ss_n, busy, core_cs, core_wr, core_rd} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 10000", {ss_n, busy, core_cs, core_wr, core_rd});
    end
    checks++;
    if (core_din !== 8'h00) begin
      failures++;
      $display("FAIL reset_din: got %h want 00", core_din);
    end
    checks++;
    if ({rx_ovf, tx_full, rx_empty} !== 3'b001) begin
      failures++;
      $display("FAIL reset_flags: got %b want 001", {rx_ovf, tx_full, rx_empty});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int base = wr_cnt;
    int pre = 0;
    int post = 0;
    bit seen = 0;
    logic [7:0] din_seen = 8'h00;
    push_word(8'hA5);
    pulse_start(8'd1);
    for (int n = 0; n < 300 && busy; n++) begin
      if (core_cs && core_wr) begin
        seen = 1;
        din_seen = core_din;
      end else if (!seen && !ss_n) begin
        pre++;
      end
      if (!rx_empty && !ss_n) post++;
      @(negedge clk);
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL single_done: busy got %0b want 0", busy);
    end
    checks++;
    if (wr_cnt - base !== 1) begin
      failures++;
      $display("FAIL single_wrs: got %0d want 1", wr_cnt - base);
    end
    checks++;
    if (din_seen !== 8'hA5) begin
      failures++;
      $display("FAIL single_din: got %h want a5", din_seen);
    end
    checks++;
    if (rx_data !== 8'h3C || rx_empty !== 1'b0) begin
      failures++;
      $display("FAIL single_rx: got %h/%0b want 3c/0", rx_data, rx_empty);
    end
    checks++;
    if (pre < SS || post < SS) begin
      failures++;
      $display("FAIL single_ss_window: pre %0d post %0d want >= %0d", pre, post, SS);
    end
    checks++;
    if (ss_n !== 1'b1) begin
      failures++;
      $display("FAIL single_ss_end: got %0b want 1", ss_n);
    end
    pop_word();
    checks++;
    if (rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: rx_empty got %0b want 1", rx_empty);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_rx [4] = '{8'h98, 8'h9B, 8'h9A, 8'h9D};
    int base = wr_cnt;
    bit first = 0;
    logic full_at_issue = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(i + 1));
    checks++;
    if (tx_full !== 1'b1) begin
      failures++;
      $display("FAIL burst_full: got %0b want 1", tx_full);
    end
    pulse_start(8'd4);
    for (int n = 0; n < 500 && busy; n++) begin
      if (!first && core_cs && core_wr) begin
        first = 1;
        full_at_issue = tx_full;
      end
      @(negedge clk);
    end
    checks++;
    if (busy || full_at_issue !== 1'b0) begin
      failures++;
      $display("FAIL burst_pop_full: busy %0b tx_full %0b want 0/0", busy, full_at_issue);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log[(base + i) % 64] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL burst_order%0d: got %h want %h", i, wr_log[(base + i) % 64], 8'(i + 1));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_data !== exp_rx[i] || rx_empty !== 1'b0) begin
        failures++;
        $display("FAIL burst_rx%0d: got %h/%0b want %h/0", i, rx_data, rx_empty, exp_rx[i]);
      end
      pop_word();
    end
    checks++;
    if (rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL burst_rx_empty: got %0b want 1", rx_empty);
    end
  endtask

  task automatic test_starve();
    int base = wr_cnt;
    int n = 0;
    pulse_start(8'd2);
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 0 || ss_n !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL starve_stall1: wrs %0d ss_n %0b busy %0b want 0/0/1", wr_cnt - base, ss_n, busy);
    end
    push_word(8'h55);
    while (rx_empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 1 || ss_n !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL starve_stall2: wrs %0d ss_n %0b busy %0b want 1/0/1", wr_cnt - base, ss_n, busy);
    end
    push_word(8'h66);
    wait_idle("starve", 300);
    checks++;
    if (wr_log[base % 64] !== 8'h55 || wr_log[(base + 1) % 64] !== 8'h66) begin
      failures++;
      $display("FAIL starve_words: got %h %h want 55 66", wr_log[base % 64], wr_log[(base + 1) % 64]);
    end
    checks++;
    if (rx_data !== 8'hCC) begin
      failures++;
      $display("FAIL starve_rx0: got %h want cc", rx_data);
    end
    pop_word();
    checks++;
    if (rx_data !== 8'hFF || rx_empty !== 1'b0) begin
      failures++;
      $display("FAIL starve_rx1: got %h/%0b want ff/0", rx_data, rx_empty);
    end
    pop_word();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_rx [4] = '{8'h88, 8'h8B, 8'h8A, 8'h8D};
    int base = wr_cnt;
    int pushed = 4;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    pulse_start(8'd6);
    for (int n = 0; n < 1000 && busy; n++) begin
      tx_push = 1'b0;
      if (pushed < 6 && !tx_full) begin
        tx_data = 8'h11 + 8'(pushed);
        tx_push = 1'b1;
        pushed++;
      end
      @(negedge clk);
    end
    tx_push = 1'b0;
    checks++;
    if (busy !== 1'b0 || rx_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: busy %0b rx_ovf %0b want 0/1", busy, rx_ovf);
    end
    checks++;
    if (wr_cnt - base !== 6 || wr_log[(base + 5) % 64] !== 8'h16) begin
      failures++;
      $display("FAIL ovf_wrs: got %0d last %h want 6 last 16", wr_cnt - base, wr_log[(base + 5) % 64]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_data !== exp_rx[i] || rx_empty !== 1'b0) begin
        failures++;
        $display("FAIL ovf_rx%0d: got %h/%0b want %h/0", i, rx_data, rx_empty, exp_rx[i]);
      end
      pop_word();
    end
    checks++;
    if (rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_rx_empty: got %0b want 1", rx_empty);
    end
  endtask

  task automatic test_edges();
    int base = wr_cnt;
    pulse_start(8'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ss_n !== 1'b1 || rx_ovf !== 1'b1) begin
      failures++;
      $display("FAIL edge_len0: busy %0b ss_n %0b ovf %0b want 0/1/1", busy, ss_n, rx_ovf);
    end
    push_word(8'h21);
    pulse_start(8'd1);
    checks++;
    if (busy !== 1'b1 || rx_ovf !== 1'b0) begin
      failures++;
      $display("FAIL edge_start: busy %0b ovf %0b want 1/0", busy, rx_ovf);
    end
    pulse_start(8'd3);
    wait_idle("edge", 300);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_cnt - base !== 1) begin
      failures++;
      $display("FAIL edge_busy_start: busy %0b wrs %0d want 0/1", busy, wr_cnt - base);
    end
    checks++;
    if (rx_data !== 8'hB8 || rx_empty !== 1'b0) begin
      failures++;
      $display("FAIL edge_rx: got %h/%0b want b8/0", rx_data, rx_empty);
    end
    pop_word();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    push_word(8'h77);
    pulse_start(8'd1);
    while (!(core_cs && core_wr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (core_done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: done %0b busy %0b want 0/1", core_done, busy);
    end
    push_word(8'h42);
    rst = 1'b0;
    #1;
    checks++;
    if ({ss_n, busy, core_cs, core_wr, core_rd, rx_ovf} !== 6'b100000) begin
      failures++;
      $display("FAIL mid_ctl: got %b want 100000", {ss_n, busy, core_cs, core_wr, core_rd, rx_ovf});
    end
    checks++;
    if (core_din !== 8'h00 || tx_full !== 1'b0 || rx_empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_data: din %h full %0b empty %0b want 00/0/1", core_din, tx_full, rx_empty);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_word(8'h5A);
    pulse_start(8'd1);
    wait_idle("mid", 300);
    checks++;
    if (rx_data !== 8'hC3 || rx_empty !== 1'b0) begin
      failures++;
      $display("FAIL mid_recover: got %h/%0b want c3/0", rx_data, rx_empty);
    end
    pop_word();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_starve();
    test_overflow();
    test_edges();
    test_reset_mid();
`ifdef SPI_XFER_SEQ_IRQ_EN
    checks++;
    if (irq_cnt !== 6) begin
      failures++;
      $display("FAIL irq_count: got %0d want 6", irq_cnt);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 Parameter DWIDTH, default 8: word width; SHALL equal the DWIDTH of the attached spi_core.
REQ-002 Parameter DEPTH, default 4: entries in each of the TX and RX FIFOs; SHALL be a power of two, at least 2.
REQ-003 Parameter SS_SETUP, default 2: clk cycles between ss_n falling and the first word issue, and between the last capture and ss_n rising.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins a transaction of len words.
REQ-007 len  in  8  number of words in the transaction, sampled on start.
REQ-008 tx_data / tx_push / tx_full  in DWIDTH / in 1 / out 1  TX FIFO write port.
REQ-009 rx_data / rx_pop / rx_empty  out DWIDTH / in 1 / out 1  RX FIFO read port; rx_data is the head entry (show-ahead).
REQ-010 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-011 rx_ovf  out  1  sticky flag: a received word was dropped.
REQ-012 ss_n  out  1  active-low slave select to the device.
REQ-013 core_cs / core_wr / core_rd / core_din  out 1/1/1/DWIDTH  drive the spi_core host port; core_rd is always 0.
REQ-014 core_dout / core_done  in DWIDTH / 1  spi_core result word and idle flag.

Function
REQ-015 States SHALL be IDLE, SETUP, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-016 IDLE: start with len!=0 SHALL load the word counter, clear rx_ovf, drive ss_n low and go to SETUP; start with len==0 SHALL be ignored.
REQ-017 SETUP: SHALL wait SS_SETUP cycles, then go to ISSUE.
REQ-018 ISSUE: when the TX FIFO is non-empty and core_done=1, SHALL assert core_cs=core_wr=1 for exactly one cycle with core_din set to the TX head, pop that entry, and go to WAIT_BUSY; when the TX FIFO is empty, SHALL stall in ISSUE with ss_n held low.
REQ-019 WAIT_BUSY: SHALL go to WAIT_DONE on the first cycle core_done=0.
REQ-020 WAIT_DONE: on the first cycle core_done=1, SHALL push core_dout into the RX FIFO, decrement the counter, and go to ISSUE if the counter is still non-zero, otherwise to HOLD.
REQ-021 HOLD: SHALL wait SS_SETUP cycles, raise ss_n, and return to IDLE; busy SHALL fall in the same cycle that ss_n rises.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 tx_push while tx_full=1 SHALL be ignored; rx_pop while rx_empty=1 SHALL be ignored.
REQ-024 A simultaneous push and pop on a full or empty FIFO SHALL be honoured; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 A capture into a full RX FIFO SHALL drop the word and set rx_ovf; the transaction SHALL continue.
REQ-026 The FIFOs SHALL be usable by the host while busy=1.

Reset
REQ-027 rst low SHALL immediately force: IDLE, ss_n=1, busy=0, core_cs=core_wr=core_rd=0, core_din=0, rx_ovf=0, both FIFOs empty (tx_full=0, rx_empty=1).
REQ-028 Reset mid-transaction SHALL abandon it; the sequencer SHALL wait for core_done=1 before the next ISSUE.

Configuration
REQ-029 Macro SPI_XFER_SEQ_IRQ_EN defined: adds output irq (1 bit, reset 0), which SHALL pulse high for one cycle on the IDLE return after a transaction.
REQ-030 Macro SPI_XFER_SEQ_IRQ_EN undefined: the irq port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 A shared package spi_pkg SHALL hold the state enumeration and the default DWIDTH/DEPTH constants.
REQ-032 The TX and RX buffers SHALL each be an instance of one sub-module, spi_sync_fifo (parameters DWIDTH, DEPTH), providing full/empty flags and show-ahead read.

Verification
REQ-033 Single word: push 0xA5, start with len=1, device returns 0x3C -> one core_wr pulse with core_din=0xA5; rx_data=0x3C; ss_n low-to-high window brackets the transfer by at least SS_SETUP cycles.
REQ-034 Burst: push 0x01..0x04, start with len=4 -> four in-order issues, RX holds four words, tx_full deasserts after the first pop.
REQ-035 Starvation: start with len=2 and an empty TX FIFO; push 0x55 after 20 cycles -> stall in ISSUE with ss_n low, then proceed; the second word stalls likewise.
REQ-036 Overflow: DEPTH=4, len=6, no rx_pop -> rx_ovf=1, RX holds the first four words, busy falls normally.
REQ-037 Edge cases: start with len=0, and start while busy -> no effect. Reset asserted mid-WAIT_DONE -> all outputs at reset values within the same cycle.
REQ-038 With SPI_XFER_SEQ_IRQ_EN defined: irq pulses exactly once per completed transaction.
